// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage. Issues loads/stores on a
// ready-handshaked data port, steers byte/half lanes, extends load data,
// stalls upstream while the access is outstanding and registers MEM/WB.
// Optional macro MEM_TIMEOUT_EN: abort a stuck access with a bus error
// after TIMEOUT_CYCLES cycles in WAIT.
//
// state | meaning
// IDLE  | no access outstanding; an aligned memop requests in this cycle
// WAIT  | request held stable, waiting for dmem_ready
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic        MisalignW,
  output logic        BusErrW
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        is_load, memop, misalign, aligned_op, abort;
  logic [1:0]  a_lo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // The wait counter must be able to reach TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_cnt_w
    $error("mem_stage: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  assign a_lo       = ALUResultM[1:0];
  assign is_load    = (ResultSrcM == 2'b01);
  assign memop      = MemWriteM | is_load;
  assign misalign   = memop & (((Funct3M[1:0] == 2'b01) & a_lo[0]) |
                               ((Funct3M[1:0] == 2'b10) & (a_lo != 2'b00)));
  assign aligned_op = memop & ~misalign;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wait counter: cleared outside WAIT, counts cycles spent in WAIT.
  always_comb cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;

  // Wait counter register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign abort = (state_q == WAIT) & ~dmem_ready &
                 (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aligned_op & ~dmem_ready) state_d = WAIT;
      WAIT:    if (dmem_ready | abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port and stall; reset gates the request immediately, even mid-WAIT.
  always_comb begin
    dmem_req   = reset & aligned_op & ~abort;
    StallM     = reset & aligned_op & ~dmem_ready & ~abort;
    dmem_we    = MemWriteM;
    dmem_addr  = {ALUResultM[31:2], 2'b00};
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    if (MemWriteM) begin
      case (Funct3M[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << a_lo;
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          dmem_be    = a_lo[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        default: dmem_be = 4'b1111;
      endcase
    end
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    case (a_lo)
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = a_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (Funct3M)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // MEM/WB register: bubble while stalled, instruction fields on retire.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      PCPlus4W   <= '0;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM & ~StallM & ~misalign & ~abort;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= (is_load & ~MemWriteM & ~StallM & ~misalign & ~abort) ? ld_ext : '0;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      MisalignW  <= misalign;
      BusErrW    <= abort;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        reset;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, dmem_rdata;
  logic [4:0]  RdM;
  logic        dmem_ready;
  logic        dmem_req, dmem_we, StallM;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        RegWriteW, MisalignW, BusErrW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;

  int pass_cnt = 0;
  int total    = 0;

  localparam logic [2:0]  LD_F3   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  localparam logic [31:0] LD_ADDR [5] = '{32'h103, 32'h101, 32'h102, 32'h100, 32'h104};
  localparam logic [31:0] LD_EXP  [5] = '{32'hFFFFFF80, 32'h000000BB, 32'hFFFF80AA,
                                          32'h0000BBCC, 32'h80AABBCC};

  mem_stage dut (
    .CLK(CLK), .reset(reset),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .MisalignW(MisalignW), .BusErrW(BusErrW)
  );

  always #5 CLK = ~CLK;

  task automatic nop();
    RegWriteM = 0; ResultSrcM = 2'b00; MemWriteM = 0; Funct3M = 3'b000;
    ALUResultM = 0; WriteDataM = 0; RdM = 0; PCPlus4M = 0;
    dmem_rdata = 0; dmem_ready = 0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr,
                      input logic [4:0] rd, input logic rdy);
    RegWriteM = 1; ResultSrcM = 2'b01; MemWriteM = 0; Funct3M = f3;
    ALUResultM = addr; RdM = rd; PCPlus4M = addr + 32'h1000; dmem_ready = rdy;
  endtask

  task automatic test_reset();
    reset = 0; nop();
    @(negedge CLK); #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", dmem_req); else pass_cnt++;
    total++; if ({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, MisalignW, BusErrW} !== '0)
      $display("FAIL reset_wb: got nonzero W outputs expected all 0"); else pass_cnt++;
    @(negedge CLK); reset = 1;
  endtask

  task automatic test_loads();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      load(LD_F3[i], LD_ADDR[i], 5'd5, 1'b1); dmem_rdata = 32'h80AABBCC; #1;
      total++; if (StallM !== 1'b0) $display("FAIL load%0d_stall: got %b expected 0", i, StallM); else pass_cnt++;
      total++; if ({dmem_req, dmem_we, dmem_be} !== 6'b10_1111)
        $display("FAIL load%0d_port: got req/we/be %b%b%b expected 101111", i, dmem_req, dmem_we, dmem_be); else pass_cnt++;
      total++; if (dmem_addr !== {LD_ADDR[i][31:2], 2'b00})
        $display("FAIL load%0d_addr: got %h expected %h", i, dmem_addr, {LD_ADDR[i][31:2], 2'b00}); else pass_cnt++;
      @(negedge CLK);
      total++; if (ReadDataW !== LD_EXP[i]) $display("FAIL load%0d_data: got %h expected %h", i, ReadDataW, LD_EXP[i]); else pass_cnt++;
      total++; if ({RegWriteW, RdW} !== {1'b1, 5'd5}) $display("FAIL load%0d_wb: got %b/%0d expected 1/5", i, RegWriteW, RdW); else pass_cnt++;
      nop();
    end
  endtask

  task automatic test_stores();
    @(negedge CLK);
    nop(); MemWriteM = 1; Funct3M = 3'b001; ALUResultM = 32'h202; WriteDataM = 32'h1234ABCD; dmem_ready = 1; #1;
    total++; if ({dmem_req, dmem_we, dmem_be} !== 6'b11_1100) $display("FAIL sh_port: got req/we/be %b%b%b expected 111100", dmem_req, dmem_we, dmem_be); else pass_cnt++;
    total++; if (dmem_wdata !== 32'hABCDABCD) $display("FAIL sh_wdata: got %h expected abcdabcd", dmem_wdata); else pass_cnt++;
    total++; if (dmem_addr !== 32'h200) $display("FAIL sh_addr: got %h expected 00000200", dmem_addr); else pass_cnt++;
    @(negedge CLK);
    Funct3M = 3'b000; ALUResultM = 32'h201; WriteDataM = 32'h000000EF; #1;
    total++; if (dmem_be !== 4'b0010) $display("FAIL sb_be: got %b expected 0010", dmem_be); else pass_cnt++;
    total++; if (dmem_wdata !== 32'hEFEFEFEF) $display("FAIL sb_wdata: got %h expected efefefef", dmem_wdata); else pass_cnt++;
    @(negedge CLK);
    Funct3M = 3'b000; ALUResultM = 32'h203; #1;
    total++; if (dmem_be !== 4'b1000) $display("FAIL sb3_be: got %b expected 1000", dmem_be); else pass_cnt++;
    @(negedge CLK);
    ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h300; WriteDataM = 32'hCAFEF00D; dmem_rdata = 32'h11111111; #1;
    total++; if ({dmem_we, dmem_be} !== 5'b1_1111) $display("FAIL sw_both_flags: got we/be %b%b expected 11111", dmem_we, dmem_be); else pass_cnt++;
    total++; if (dmem_wdata !== 32'hCAFEF00D) $display("FAIL sw_wdata: got %h expected cafef00d", dmem_wdata); else pass_cnt++;
    @(negedge CLK);
    total++; if ({RegWriteW, ReadDataW} !== 33'd0) $display("FAIL sw_wb: got %b/%h expected 0/0", RegWriteW, ReadDataW); else pass_cnt++;
    nop();
  endtask

  task automatic test_wait_states();
    @(negedge CLK);
    load(3'b010, 32'h400, 5'd9, 1'b0); #1;
    for (int i = 0; i < 3; i++) begin
      total++; if ({StallM, dmem_req} !== 2'b11) $display("FAIL wait%0d_stall: got %b%b expected 11", i, StallM, dmem_req); else pass_cnt++;
      total++; if (dmem_addr !== 32'h400) $display("FAIL wait%0d_addr: got %h expected 00000400", i, dmem_addr); else pass_cnt++;
      @(negedge CLK);
      total++; if (RegWriteW !== 1'b0) $display("FAIL wait%0d_bubble: got %b expected 0", i, RegWriteW); else pass_cnt++;
      if (i == 2) begin dmem_ready = 1; dmem_rdata = 32'hDEADBEEF; end
      #1;
    end
    total++; if ({StallM, dmem_req} !== 2'b01) $display("FAIL wait_done: got stall/req %b%b expected 01", StallM, dmem_req); else pass_cnt++;
    @(negedge CLK);
    total++; if ({RegWriteW, ReadDataW, RdW} !== {1'b1, 32'hDEADBEEF, 5'd9})
      $display("FAIL wait_wb: got %b/%h/%0d expected 1/deadbeef/9", RegWriteW, ReadDataW, RdW); else pass_cnt++;
    nop();
  endtask

  task automatic test_misalign();
    @(negedge CLK);
    load(3'b010, 32'h101, 5'd4, 1'b0); #1;
    total++; if ({dmem_req, StallM} !== 2'b00) $display("FAIL lw_mis_req: got req/stall %b%b expected 00", dmem_req, StallM); else pass_cnt++;
    @(negedge CLK);
    total++; if ({MisalignW, RegWriteW, BusErrW} !== 3'b100) $display("FAIL lw_mis_wb: got mis/rw/be %b%b%b expected 100", MisalignW, RegWriteW, BusErrW); else pass_cnt++;
    load(3'b101, 32'h103, 5'd4, 1'b0); #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL lhu_mis_req: got %b expected 0", dmem_req); else pass_cnt++;
    @(negedge CLK);
    total++; if ({MisalignW, RegWriteW} !== 2'b10) $display("FAIL lhu_mis_wb: got %b%b expected 10", MisalignW, RegWriteW); else pass_cnt++;
    load(3'b001, 32'h102, 5'd4, 1'b1); dmem_rdata = 32'h00007FFF; #1;
    total++; if (dmem_req !== 1'b1) $display("FAIL lh_aligned_req: got %b expected 1", dmem_req); else pass_cnt++;
    @(negedge CLK);
    total++; if ({MisalignW, RegWriteW, ReadDataW} !== {2'b01, 32'h00000000})
      $display("FAIL lh_aligned_wb: got %b%b/%h expected 01/00000000", MisalignW, RegWriteW, ReadDataW); else pass_cnt++;
    nop();
  endtask

  task automatic test_nonmem();
    @(negedge CLK);
    nop(); RegWriteM = 1; ResultSrcM = 2'b10; ALUResultM = 32'h12345678; PCPlus4M = 32'h44; RdM = 5'd7;
    dmem_rdata = 32'hFFFFFFFF; #1;
    total++; if ({dmem_req, StallM} !== 2'b00) $display("FAIL alu_req: got %b%b expected 00", dmem_req, StallM); else pass_cnt++;
    @(negedge CLK);
    total++; if ({RegWriteW, ResultSrcW, RdW, MisalignW} !== {1'b1, 2'b10, 5'd7, 1'b0})
      $display("FAIL alu_ctrl: got %b/%b/%0d/%b expected 1/10/7/0", RegWriteW, ResultSrcW, RdW, MisalignW); else pass_cnt++;
    total++; if ({ALUResultW, PCPlus4W, ReadDataW} !== {32'h12345678, 32'h44, 32'h0})
      $display("FAIL alu_data: got %h/%h/%h expected 12345678/00000044/00000000", ALUResultW, PCPlus4W, ReadDataW); else pass_cnt++;
    nop();
  endtask

  task automatic test_timeout();
    @(negedge CLK);
    load(3'b010, 32'h600, 5'd2, 1'b0); #1;
    total++; if (StallM !== 1'b1) $display("FAIL tmo_first: got %b expected 1", StallM); else pass_cnt++;
`ifdef MEM_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK); #1;
      total++; if (StallM !== 1'b1) $display("FAIL tmo_wait%0d: got %b expected 1", k, StallM); else pass_cnt++;
    end
    @(negedge CLK); #1;
    total++; if ({StallM, dmem_req} !== 2'b00) $display("FAIL tmo_abort: got stall/req %b%b expected 00", StallM, dmem_req); else pass_cnt++;
    @(negedge CLK);
    total++; if ({BusErrW, RegWriteW} !== 2'b10) $display("FAIL tmo_wb: got %b%b expected 10", BusErrW, RegWriteW); else pass_cnt++;
    nop();
`else
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK); #1;
      total++; if ({StallM, dmem_req, BusErrW} !== 3'b110) $display("FAIL hold%0d: got stall/req/buserr %b%b%b expected 110", k, StallM, dmem_req, BusErrW); else pass_cnt++;
    end
    dmem_ready = 1; dmem_rdata = 32'h0BADF00D; #1;
    total++; if (StallM !== 1'b0) $display("FAIL hold_release: got %b expected 0", StallM); else pass_cnt++;
    @(negedge CLK);
    total++; if ({BusErrW, RegWriteW, ReadDataW} !== {2'b01, 32'h0BADF00D})
      $display("FAIL hold_wb: got %b%b/%h expected 01/0badf00d", BusErrW, RegWriteW, ReadDataW); else pass_cnt++;
    nop();
`endif
  endtask

  task automatic test_reset_midwait();
    @(negedge CLK);
    load(3'b010, 32'h500, 5'd3, 1'b0);
    @(negedge CLK); @(negedge CLK);
    reset = 0; #1;
    total++; if ({dmem_req, StallM} !== 2'b00) $display("FAIL rst_mid_req: got req/stall %b%b expected 00", dmem_req, StallM); else pass_cnt++;
    total++; if ({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, MisalignW, BusErrW} !== '0)
      $display("FAIL rst_mid_wb: got alu %h pc %h rd %0d expected all 0", ALUResultW, PCPlus4W, RdW); else pass_cnt++;
    @(negedge CLK); #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL rst_hold_req: got %b expected 0", dmem_req); else pass_cnt++;
    nop(); reset = 1;
    @(negedge CLK); #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL rst_rel_req: got %b expected 0", dmem_req); else pass_cnt++;
    load(3'b010, 32'h700, 5'd8, 1'b1); dmem_rdata = 32'h13579BDF; #1;
    total++; if ({dmem_req, StallM} !== 2'b10) $display("FAIL rst_after_req: got %b%b expected 10", dmem_req, StallM); else pass_cnt++;
    @(negedge CLK);
    total++; if ({RegWriteW, ReadDataW} !== {1'b1, 32'h13579BDF}) $display("FAIL rst_after_wb: got %b/%h expected 1/13579bdf", RegWriteW, ReadDataW); else pass_cnt++;
    nop();
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_wait_states();
    test_misalign();
    test_nonmem();
    test_timeout();
    test_reset_midwait();
    @(negedge CLK);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total);
    $fatal(1, "watchdog expired");
  end

endmodule
